// File: rtl/pipe_sequencer.sv
// pipe_sequencer: hazard stall/flush control plus SYSCALL drain, host handshake and halt sequencing
module pipe_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_sys,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_redirect,
  input  logic             ex_valid,
  input  logic             mem_valid,
  input  logic             wb_valid,
  input  logic             sys_ack,
  input  logic             sys_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             sys_req,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, DRAIN, SYS_WAIT, HALT} state_e;
  state_e state_q;
  logic sys_req_q, halted_q;
  logic [CNT_W-1:0] cnt_q;
  logic luse, empty, run, hold, abort, resume;
  assign luse = ex_memread & (ex_rt != 5'd0) & id_valid & (ex_rt == id_rs | (id_uses_rt & ex_rt == id_rt));
  assign empty = ~ex_valid & ~mem_valid & ~wb_valid;
  assign run = state_q == RUN;
  assign hold = luse | (id_valid & id_sys);
  assign abort = state_q == DRAIN & ex_redirect;
  assign resume = state_q == SYS_WAIT & sys_ack & ~sys_halt;
  assign pc_en = run ? (ex_redirect | ~hold) : (abort | resume);
  assign ifid_en = run ? (ex_redirect | ~hold) : resume;
  assign ifid_flush = run ? ex_redirect : (abort | resume);
  assign idex_bubble = run ? (ex_redirect | hold) : 1'b1;
  assign sys_req = sys_req_q;
  assign halted = halted_q;
  assign stall_cnt = cnt_q;
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= RUN;
      sys_req_q <= 1'b0;
      halted_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (!pc_en && state_q != HALT && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
      case (state_q)
        RUN: if (!ex_redirect && !luse && id_valid && id_sys) state_q <= DRAIN;
        DRAIN: begin
          if (ex_redirect) state_q <= RUN;
          else if (empty) begin
            state_q <= SYS_WAIT;
            sys_req_q <= 1'b1;
          end
        end
        SYS_WAIT: begin
          if (sys_ack) begin
            sys_req_q <= 1'b0;
            halted_q <= sys_halt;
            state_q <= sys_halt ? HALT : RUN;
          end
        end
        default: state_q <= HALT;
      endcase
    end
  end
endmodule
